placed_ctrl: RTL and testbench

PLACED_CTRL -- requirements
Module: placed_ctrl

---
 rtl/placed_ctrl.sv | 102 ++++++++++
 tb/tb_placed_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/placed_ctrl.sv
// placed_ctrl: card-board cell controller; clears the cell RAM after reset, then serves place/remove requests.
// Optional occupancy counter port enabled by defining PLACED_CTRL_OCCUPANCY_EN.
module placed_ctrl #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 45
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_remove,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [SIZE-1:0]          req_card,
  output logic                     resp_valid,
  output logic                     resp_ok,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] ram_address,
  output logic [SIZE-1:0]          ram_write_data,
  output logic                     ram_write_en,
  input  logic [SIZE-1:0]          ram_read_data
`ifdef PLACED_CTRL_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {CLEAR, IDLE, RD, CHK, RESP} state_t;
  state_t state, state_nx;
  logic [AW-1:0] sweep, addr_q;
  logic [SIZE-1:0] card_q;
  logic remove_q, ok_q, ok, sweep_end;
  assign sweep_end = sweep == AW'(DEPTH - 1);
  // ram_read_data is valid in CHK because the address was already driven during RD
  assign ok = (32'(addr_q) < DEPTH) &&
              (remove_q ? ram_read_data != '0 : (ram_read_data == '0 && card_q != '0));
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_ok = 1'b0;
    ram_address = '0;
    ram_write_data = '0;
    ram_write_en = 1'b0;
    case (state)
      CLEAR: begin
        ram_address = sweep;
        ram_write_en = 1'b1;
        state_nx = sweep_end ? IDLE : CLEAR;
      end
      IDLE: begin
        req_ready = 1'b1;
        state_nx = req_valid ? RD : IDLE;
      end
      RD: begin
        ram_address = addr_q;
        state_nx = CHK;
      end
      CHK: begin
        ram_address = addr_q;
        ram_write_en = ok;
        ram_write_data = (ok && !remove_q) ? card_q : '0;
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_ok = ok_q;
        state_nx = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      sweep <= '0;
      addr_q <= '0;
      card_q <= '0;
      remove_q <= 1'b0;
      ok_q <= 1'b0;
    end else begin
      state <= state_nx;
      sweep <= (state == CLEAR && !sweep_end) ? sweep + 1'b1 : '0;
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        card_q <= req_card;
        remove_q <= req_remove;
      end
      if (state == CHK) ok_q <= ok;
    end
  end
`ifdef PLACED_CTRL_OCCUPANCY_EN
  localparam int OW = $clog2(DEPTH + 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occupancy <= '0;
    else if (state == CLEAR) occupancy <= '0;
    else if (state == CHK && ok)
      occupancy <= remove_q ? (occupancy == '0 ? occupancy : occupancy - 1'b1)
                            : (occupancy == OW'(DEPTH) ? occupancy : occupancy + 1'b1);
  end
`endif
endmodule

// File: tb/tb_placed_ctrl.sv
// tb_placed_ctrl: directed table plus random requests against a cell-array model of the board.
module tb_placed_ctrl;
  localparam int SIZE = 8;
  localparam int DEPTH = 45;
  localparam int AW = $clog2(DEPTH);
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_remove = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [SIZE-1:0] req_card = '0;
  logic req_ready, resp_valid, resp_ok, busy, ram_write_en;
  logic [AW-1:0] ram_address;
  logic [SIZE-1:0] ram_write_data;
  logic [SIZE-1:0] ram_read_data = '0;
`ifdef PLACED_CTRL_OCCUPANCY_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif
  logic [SIZE-1:0] mem [DEPTH] = '{default: 8'h5A};
  logic [SIZE-1:0] model_mem [DEPTH];
  int model_occ = 0;
  int n_checks = 0, n_fail = 0;

  placed_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_remove(req_remove), .req_addr(req_addr), .req_card(req_card),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .busy(busy),
    .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_write_en(ram_write_en), .ram_read_data(ram_read_data)
`ifdef PLACED_CTRL_OCCUPANCY_EN
    , .occupancy(occupancy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_read_data <= (32'(ram_address) < DEPTH) ? mem[ram_address] : '0;
    if (ram_write_en && 32'(ram_address) < DEPTH) mem[ram_address] <= ram_write_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic model_ok(input logic rm, input logic [AW-1:0] a, input logic [SIZE-1:0] c);
    if (32'(a) >= DEPTH) return 1'b0;
    return rm ? (model_mem[a] != '0) : (model_mem[a] == '0 && c != '0);
  endfunction

  task automatic reset_vals(input string nm);
    chk({nm, "_ready"}, req_ready, 0);
    chk({nm, "_resp_valid"}, resp_valid, 0);
    chk({nm, "_resp_ok"}, resp_ok, 0);
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_addr"}, ram_address, 0);
    chk({nm, "_wdata"}, ram_write_data, 0);
    chk({nm, "_we"}, ram_write_en, 1);
  endtask

  // Releases reset at a falling edge and follows the whole clear sweep.
  task automatic sweep_check(input string nm);
    int bad, nz;
    bad = 0;
    nz = 0;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram_write_en !== 1'b1 || ram_address !== AW'(i) || ram_write_data !== '0 ||
          resp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk({nm, "_sweep_bad_cycles"}, bad, 0);
    chk({nm, "_ready_after_sweep"}, req_ready, 1);
    chk({nm, "_busy_after_sweep"}, busy, 0);
    chk({nm, "_we_idle"}, ram_write_en, 0);
    chk({nm, "_addr_idle"}, ram_address, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] != '0) nz++;
      model_mem[i] = '0;
    end
    chk({nm, "_nonzero_cells"}, nz, 0);
    model_occ = 0;
`ifdef PLACED_CTRL_OCCUPANCY_EN
    chk({nm, "_occupancy"}, occupancy, 0);
`endif
  endtask

  task automatic do_req(input logic rm, input logic [AW-1:0] a, input logic [SIZE-1:0] c,
                        input logic exp_ok, input string nm);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_remove = rm;
    req_addr = a;
    req_card = c;
    @(negedge clk);
    req_valid = 1'b0;
    req_remove = ~rm;
    req_addr = ~a;
    req_card = ~c;
    chk({nm, "_rd_we"}, ram_write_en, 0);
    chk({nm, "_rd_addr"}, ram_address, a);
    chk({nm, "_rd_resp"}, resp_valid, 0);
    chk({nm, "_rd_ready"}, req_ready, 0);
    chk({nm, "_rd_busy"}, busy, 1);
    @(negedge clk);
    chk({nm, "_chk_we"}, ram_write_en, exp_ok);
    chk({nm, "_chk_addr"}, ram_address, a);
    if (exp_ok) chk({nm, "_chk_wdata"}, ram_write_data, rm ? 0 : c);
    chk({nm, "_chk_resp"}, resp_valid, 0);
    @(negedge clk);
    if (exp_ok) begin
      model_mem[a] = rm ? '0 : c;
      model_occ = rm ? (model_occ > 0 ? model_occ - 1 : 0) : (model_occ < DEPTH ? model_occ + 1 : DEPTH);
    end
    chk({nm, "_resp_valid"}, resp_valid, 1);
    chk({nm, "_resp_ok"}, resp_ok, exp_ok);
    chk({nm, "_resp_we"}, ram_write_en, 0);
`ifdef PLACED_CTRL_OCCUPANCY_EN
    chk({nm, "_occupancy"}, occupancy, model_occ);
`endif
    @(negedge clk);
    chk({nm, "_resp_drop"}, resp_valid, 0);
    chk({nm, "_ready_again"}, req_ready, 1);
    if (32'(a) < DEPTH) chk({nm, "_cell"}, mem[a], model_mem[a]);
  endtask

  typedef struct {
    logic rm;
    logic [AW-1:0] a;
    logic [SIZE-1:0] c;
    logic ok;
    string nm;
  } vec_t;
  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b0, 6'd3,  8'd5,   1'b1, "place5_c3"};
    vecs[1]  = '{1'b0, 6'd3,  8'd7,   1'b0, "place7_occupied"};
    vecs[2]  = '{1'b1, 6'd3,  8'd0,   1'b1, "remove_c3"};
    vecs[3]  = '{1'b1, 6'd3,  8'd0,   1'b0, "remove_c3_again"};
    vecs[4]  = '{1'b0, 6'd10, 8'd0,   1'b0, "place_card0"};
    vecs[5]  = '{1'b0, 6'd50, 8'd9,   1'b0, "place_addr50"};
    vecs[6]  = '{1'b1, 6'd50, 8'd0,   1'b0, "remove_addr50"};
    vecs[7]  = '{1'b0, 6'd44, 8'hFF, 1'b1, "place_last_cell"};
    vecs[8]  = '{1'b0, 6'd0,  8'd1,   1'b1, "place_cell0"};
    vecs[9]  = '{1'b1, 6'd44, 8'd0,   1'b1, "remove_last_cell"};
    vecs[10] = '{1'b1, 6'd0,  8'd0,   1'b1, "remove_cell0"};

    repeat (3) @(negedge clk);
    reset_vals("in_reset");
    sweep_check("init");

    for (int i = 0; i < 11; i++)
      do_req(vecs[i].rm, vecs[i].a, vecs[i].c, vecs[i].ok, vecs[i].nm);

    for (int i = 0; i < 40; i++) begin
      logic rm;
      logic [AW-1:0] a;
      logic [SIZE-1:0] c;
      rm = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(45, 63)) : AW'($urandom_range(0, 5));
      c = SIZE'($urandom_range(0, 3));
      do_req(rm, a, c, model_ok(rm, a, c), $sformatf("rnd%0d", i));
    end

    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1;
    req_remove = 1'b0;
    req_addr = 6'd7;
    req_card = 8'd9;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_vals("midreq_reset");
    begin
      int rv;
      rv = 0;
      repeat (2) begin
        @(negedge clk);
        if (resp_valid !== 1'b0) rv++;
      end
      chk("midreq_no_resp_in_reset", rv, 0);
    end
    sweep_check("midreq");
    req_valid = 1'b0;
    do_req(1'b0, 6'd7, 8'd9, 1'b1, "after_midreq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
